// File: rtl/writeback_arbiter.sv
// Writeback arbiter: shares the register-file and vector-file write ports between the
// scalar (mem stage) and vector pipeline results, deferring vector results in per-port FIFOs.
module writeback_arbiter #(
    parameter int SDATA_W   = 36,
    parameter int VDATA_W   = 128,
    parameter int BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic                         s_vec,
    input  logic [4:0]                   s_dest,
    input  logic [VDATA_W-1:0]           s_data,
    input  logic                         v_valid,
    input  logic                         v_vec,
    input  logic [4:0]                   v_dest,
    input  logic [VDATA_W-1:0]           v_data,
    input  logic                         defer_register,
    input  logic                         defer_vector,
    output logic                         s_stall,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [SDATA_W-1:0]           rf_wdata,
    output logic                         vf_we,
    output logic [4:0]                   vf_waddr,
    output logic [VDATA_W-1:0]           vf_wdata,
    output logic [$clog2(BUF_DEPTH):0]   reg_buf_count,
    output logic [$clog2(BUF_DEPTH):0]   vec_buf_count,
    output logic                         overflow_err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {SRC_NONE, SRC_SCALAR, SRC_VECTOR, SRC_FIFO} src_e;

    // Channel index 0 is the register port, 1 is the vector port.
    logic [1:0]         sw, vw, dfr, full;
    logic [1:0]         enq, deq, push, blk;
    src_e               sel [2];

    logic [SDATA_W-1:0] rmem_q [BUF_DEPTH];
    logic [VDATA_W-1:0] vmem_q [BUF_DEPTH];
    logic [4:0]         dmem_q [2][BUF_DEPTH];

    logic [PW-1:0]      wptr_q [2], wptr_d [2];
    logic [PW-1:0]      rptr_q [2], rptr_d [2];
    logic [CW-1:0]      cnt_q [2], cnt_d [2];
    logic [1:0]         we_q, we_d;
    logic [4:0]         waddr_q [2], waddr_d [2];
    logic [SDATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [VDATA_W-1:0] vf_wdata_q, vf_wdata_d;
    logic               ovf_q, ovf_d;

    assign sw   = {s_valid & s_vec, s_valid & ~s_vec};
    assign vw   = {v_valid & v_vec, v_valid & ~v_vec};
    assign dfr  = {defer_vector, defer_register};
    assign full = {cnt_q[1] == CW'(BUF_DEPTH), cnt_q[0] == CW'(BUF_DEPTH)};

    always_comb begin
        enq   = '0;
        deq   = '0;
        push  = '0;
        blk   = '0;
        we_d  = '0;
        ovf_d = ovf_q;
        for (int c = 0; c < 2; c++) begin
            sel[c]     = SRC_NONE;
            waddr_d[c] = '0;
            // Deferral only matters when there is a vector result to defer.
            if (dfr[c] && vw[c]) begin
                enq[c] = 1'b1;
                if (sw[c]) sel[c] = SRC_SCALAR;
            end else if (cnt_q[c] != '0) begin
                sel[c] = SRC_FIFO;
                deq[c] = 1'b1;
                enq[c] = vw[c];
                blk[c] = sw[c];
            end else if (vw[c]) begin
                sel[c] = SRC_VECTOR;
                blk[c] = sw[c];
            end else if (sw[c]) begin
                sel[c] = SRC_SCALAR;
            end

            push[c] = enq[c] && (!full[c] || deq[c]);
            if (enq[c] && full[c] && !deq[c]) ovf_d = 1'b1;

            wptr_d[c] = wptr_q[c] + PW'(push[c]);
            rptr_d[c] = rptr_q[c] + PW'(deq[c]);
            cnt_d[c]  = cnt_q[c] + CW'(push[c]) - CW'(deq[c]);
            we_d[c]   = (sel[c] != SRC_NONE);

            case (sel[c])
                SRC_SCALAR: waddr_d[c] = s_dest;
                SRC_VECTOR: waddr_d[c] = v_dest;
                SRC_FIFO:   waddr_d[c] = dmem_q[c][rptr_q[c]];
                default:    waddr_d[c] = '0;
            endcase
        end

        case (sel[0])
            SRC_SCALAR: rf_wdata_d = s_data[SDATA_W-1:0];
            SRC_VECTOR: rf_wdata_d = v_data[SDATA_W-1:0];
            SRC_FIFO:   rf_wdata_d = rmem_q[rptr_q[0]];
            default:    rf_wdata_d = '0;
        endcase
        case (sel[1])
            SRC_SCALAR: vf_wdata_d = s_data;
            SRC_VECTOR: vf_wdata_d = v_data;
            SRC_FIFO:   vf_wdata_d = vmem_q[rptr_q[1]];
            default:    vf_wdata_d = '0;
        endcase

        s_stall = |blk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                cnt_q[c]   <= '0;
                waddr_q[c] <= '0;
            end
            we_q       <= '0;
            rf_wdata_q <= '0;
            vf_wdata_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
                cnt_q[c]   <= cnt_d[c];
                waddr_q[c] <= waddr_d[c];
            end
            we_q       <= we_d;
            rf_wdata_q <= rf_wdata_d;
            vf_wdata_q <= vf_wdata_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage is not reset; the pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (push[0]) begin
            rmem_q[wptr_q[0]]    <= v_data[SDATA_W-1:0];
            dmem_q[0][wptr_q[0]] <= v_dest;
        end
        if (push[1]) begin
            vmem_q[wptr_q[1]]    <= v_data;
            dmem_q[1][wptr_q[1]] <= v_dest;
        end
    end

    assign rf_we         = we_q[0];
    assign rf_waddr      = waddr_q[0];
    assign rf_wdata      = rf_wdata_q;
    assign vf_we         = we_q[1];
    assign vf_waddr      = waddr_q[1];
    assign vf_wdata      = vf_wdata_q;
    assign reg_buf_count = cnt_q[0];
    assign vec_buf_count = cnt_q[1];
    assign overflow_err  = ovf_q;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Owns the register-file and vector-file write ports at the writeback stage. Shares each port between the scalar pipeline result (mem stage) and the vector pipeline result (last vector stage).
- Vector results that must retire after an older scalar result, or behind earlier deferred results, are held in a per-port FIFO and drained in order.
- The vector pipeline never stalls. The scalar pipeline is stalled when it loses a port.

Parameters:
SDATA_W, 36, scalar register data width
VDATA_W, 128, vector register data width
BUF_DEPTH, 4, entries per deferral FIFO (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
s_valid  input  1  scalar result present at mem stage
s_vec  input  1  scalar result target: 1=vector file, 0=register file
s_dest  input  5  scalar destination register
s_data  input  VDATA_W  scalar result (low SDATA_W bits used for register file)
v_valid  input  1  vector pipeline result present
v_vec  input  1  vector result target: 1=vector file, 0=register file
v_dest  input  5  vector destination register
v_data  input  VDATA_W  vector result
defer_register  input  1  vector register-file result is newer than the scalar result; must retire after it
defer_vector  input  1  same, for the vector file
s_stall  output  1  scalar result not accepted this cycle (combinational)
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  SDATA_W  register-file write data (registered)
vf_we  output  1  vector-file write enable (registered)
vf_waddr  output  5  vector-file write address (registered)
vf_wdata  output  VDATA_W  vector-file write data (registered)
reg_buf_count  output  clog2(BUF_DEPTH)+1  register FIFO occupancy
vec_buf_count  output  clog2(BUF_DEPTH)+1  vector FIFO occupancy
overflow_err  output  1  sticky: enqueue attempted into a full FIFO

Behaviour:
- Reset: the listed outputs are 0, both FIFOs are empty, pointers are 0, and overflow_err=0. Reset mid-operation discards all buffered entries.
- Two independent port channels, P in {register, vector}. Per channel each cycle:
  - sw = s_valid and the scalar result targets P.
  - vw = v_valid and the vector result targets P.
  - dfr = the defer input for P.
  - ne = the FIFO for P is non-empty.
- Channel priority (evaluated in order):
  1. dfr=1: grant the scalar result if sw; enqueue the vector result if vw; no dequeue. dfr with vw=0 is ignored (fall through to rule 2).
  2. ne=1: write the FIFO head and dequeue; enqueue the vector result if vw; if sw, the scalar result is blocked.
  3. vw=1: write the vector result directly; if sw, the scalar result is blocked.
  4. sw=1: write the scalar result.
  5. Otherwise: no write on P.
- s_stall = OR of the blocked conditions across both channels. A stalled scalar result holds its inputs and is re-evaluated next cycle.
- Ordering: a vector result bypasses its FIFO only when that FIFO is empty and dfr=0, so per-port writes follow vector program order.
- Write latency is one cycle: the grant decision in cycle N appears on the write port in cycle N+1. The write port carries the granted source's dest and data; the register port truncates data to SDATA_W.
- FIFO: circular, with read and write pointers wrapping modulo BUF_DEPTH.
  - Simultaneous enqueue and dequeue is legal at any occupancy, including full; count is unchanged.
  - Enqueue while full with no dequeue: the entry is dropped, overflow_err is set and holds until reset, and count stays BUF_DEPTH.
  - Dequeue only when non-empty.
- Both channels may write in the same cycle (scalar to one port, vector or buffer to the other).
- s_valid=0 never asserts s_stall.

Test Plan:
- Reset, then scalar reg write: s_valid=1, s_vec=0, s_dest=3, data=0x5, all else idle → s_stall=0; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x5; vf_we=0.
- Port conflict: scalar to reg r4 and vector to reg r9 in the same cycle, defer_register=0 → s_stall=1; next cycle rf_waddr=9; scalar held and written the cycle after (rf_waddr=4).
- Deferral: scalar r4=0xA, vector r4=0xB, defer_register=1 → s_stall=0, reg_buf_count=1. Next cycle rf_wdata=0xA; the cycle after rf_wdata=0xB and reg_buf_count=0.
- Ordering: with the reg FIFO holding one entry r7, a live vector reg result r8 with no defer → head r7 written first, r8 enqueued, r8 written next cycle.
- Full and overflow: BUF_DEPTH=4, fill the vector FIFO via defer_vector for 4 cycles with scalar vector writes.
  - 5th deferred enqueue while the scalar still holds the port → overflow_err=1 and vec_buf_count stays 4.
  - Enqueue plus dequeue at full → count stays 4 and overflow_err is not raised by that cycle.
- Dual port and reset: scalar reg write plus vector vf write together → both rf_we and vf_we next cycle, s_stall=0. Assert rst with 2 entries buffered → counts, we and overflow_err read 0 on the next cycle.
